// File: rtl/timer_pkg.sv
// timer_pkg: register map, TCR/TSR bit positions and prescaler divider table
package timer_pkg;
  localparam logic [1:0] REG_TDR  = 2'd0;
  localparam logic [1:0] REG_TCR  = 2'd1;
  localparam logic [1:0] REG_TSR  = 2'd2;
  localparam logic [1:0] REG_TCNT = 2'd3;
  localparam int TCR_LOAD   = 7;
  localparam int TCR_AR     = 6;
  localparam int TCR_DW     = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_UDF_IE = 3;
  localparam int TCR_OVF_IE = 2;
  localparam int TCR_SEL    = 0;
  localparam int TSR_UDF    = 1;
  localparam int TSR_OVF    = 0;
  typedef enum logic [1:0] {CS_DIV2, CS_DIV4, CS_DIV8, CS_DIV16} clk_sel_e;
  localparam int DIV_N [4] = '{2, 4, 8, 16};
  function automatic logic [3:0] div_last(clk_sel_e sel);
    return 4'(DIV_N[int'(sel)] - 1);
  endfunction
endpackage

// File: rtl/timer_multi_ch_if.sv
// timer_multi_ch_if: zero-wait-state APB bus between a master and the timer block
interface timer_multi_ch_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/timer_ch.sv
// timer_ch: one timer channel with prescaler, up/down counter and TDR/TCR/TSR
module timer_ch
  import timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_i,
  input  logic [1:0]       reg_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] tdr_o,
  output logic [7:0]       tcr_o,
  output logic [1:0]       tsr_o,
  output logic [CNT_W-1:0] tcnt_o,
  output logic             irq_o
);
  logic [CNT_W-1:0] tdr_q, tdr_d, tcnt_q, tcnt_d;
  logic [7:0]       tcr_q, tcr_d;
  logic [1:0]       tsr_q, tsr_d, set;
  logic [3:0]       pre_q, pre_d;
  clk_sel_e         sel_q, sel_eff;
  logic             run, tick, dw, wrap;
  logic             unused_w;
  assign unused_w = ^wdata_i;
  // next-state: the divider picks up a new clk_sel only when it sits at zero
  always_comb begin
    run     = tcr_q[TCR_EN] & ~tcr_q[TCR_LOAD];
    dw      = tcr_q[TCR_DW];
    sel_eff = pre_q == 4'd0 ? clk_sel_e'(tcr_q[TCR_SEL+1:TCR_SEL]) : sel_q;
    tick    = run & (pre_q == div_last(sel_eff));
    pre_d   = (!run || tick) ? 4'd0 : pre_q + 4'd1;
    wrap    = tick & (dw ? ~|tcnt_q : &tcnt_q);
    set     = {wrap & dw, wrap & ~dw};
    tcnt_d  = tcr_q[TCR_LOAD] ? tdr_q :
              !tick ? tcnt_q :
              wrap ? (tcr_q[TCR_AR] ? tdr_q : (dw ? '1 : '0)) :
              dw ? tcnt_q - CNT_W'(1) : tcnt_q + CNT_W'(1);
    tdr_d   = (wr_i && reg_i == REG_TDR) ? wdata_i[CNT_W-1:0] : tdr_q;
    tcr_d   = (wr_i && reg_i == REG_TCR) ? wdata_i[7:0] : tcr_q;
    tsr_d   = (tsr_q & ((wr_i && reg_i == REG_TSR) ? wdata_i[1:0] : 2'b11)) | set;
  end
  // channel state registers
  always_ff @(posedge clk)
    if (rst) begin
      tdr_q  <= '0;
      tcr_q  <= '0;
      tsr_q  <= '0;
      tcnt_q <= '0;
      pre_q  <= '0;
      sel_q  <= CS_DIV2;
    end else begin
      tdr_q  <= tdr_d;
      tcr_q  <= tcr_d;
      tsr_q  <= tsr_d;
      tcnt_q <= tcnt_d;
      pre_q  <= pre_d;
      sel_q  <= sel_eff;
    end
  assign tdr_o  = tdr_q;
  assign tcr_o  = tcr_q;
  assign tsr_o  = tsr_q;
  assign tcnt_o = tcnt_q;
  assign irq_o  = (tsr_q[TSR_UDF] & tcr_q[TCR_UDF_IE]) | (tsr_q[TSR_OVF] & tcr_q[TCR_OVF_IE]);
endmodule

// File: rtl/timer_multi_ch.sv
// timer_multi_ch: APB-mapped bank of NUM_CH independent timers with readback mux
module timer_multi_ch
  import timer_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
) (
  input  logic                pclk,
  input  logic                preset,
  timer_multi_ch_if.slave     apb,
  output logic [NUM_CH-1:0]   irq
);
  logic [1:0]  ch, rg;
  logic        valid, wr;
  logic [31:0] rd_ch [4];
  logic        unused_a;
  assign unused_a = ^{apb.paddr[7:6], apb.paddr[1:0]};
  assign ch    = apb.paddr[5:4];
  assign rg    = apb.paddr[3:2];
  assign valid = int'(ch) < NUM_CH;
  assign wr    = apb.psel & apb.penable & apb.pwrite;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = apb.psel & apb.penable & ~valid;
  assign apb.prdata  = apb.psel ? rd_ch[ch] : '0;
  for (genvar c = 0; c < 4; c++) begin : g_ch
    if (c < NUM_CH) begin : g_on
      logic [CNT_W-1:0] tdr, tcnt;
      logic [7:0]       tcr;
      logic [1:0]       tsr;
      timer_ch #(.CNT_W(CNT_W)) u_ch (
        .clk    (pclk),
        .rst    (preset),
        .wr_i   (wr && ch == 2'(c)),
        .reg_i  (rg),
        .wdata_i(apb.pwdata),
        .tdr_o  (tdr),
        .tcr_o  (tcr),
        .tsr_o  (tsr),
        .tcnt_o (tcnt),
        .irq_o  (irq[c])
      );
      assign rd_ch[c] = rg == REG_TDR ? 32'(tdr) :
                        rg == REG_TCR ? 32'(tcr) :
                        rg == REG_TSR ? 32'(tsr) : 32'(tcnt);
    end else begin : g_off
      assign rd_ch[c] = '0;
    end
  end
endmodule

// File: doc/timer_multi_ch.md
TIMER_MULTI_CH -- requirements
Module: timer_multi_ch

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (1..4).
REQ-002 SHALL have parameter CNT_W, default 8, counter width in bits (8..32).
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 pclk  input  1  APB clock; all logic on rising edge.
REQ-005 preset  input  1  synchronous active-high reset.
REQ-006 psel, penable, pwrite  input  1 each  APB control.
REQ-007 paddr  input  8  byte address; channel = paddr[5:4], register = paddr[3:2].
REQ-008 pwdata  input  32  write data; prdata  output  32  read data.
REQ-009 pready  output  1  always 1 (zero wait states); pslverr  output  1  error response.
REQ-010 irq  output  NUM_CH  per-channel level interrupt.

Function
REQ-011 Per-channel registers: 0x0 TDR (RW, CNT_W), 0x4 TCR (RW, 8 bits), 0x8 TSR (RW0C, 2 bits), 0xC TCNT (RO, CNT_W); unused upper bits read 0.
REQ-012 TCR bits: [7] load, [6] auto-reload, [5] dw, [4] en, [3] udf_ie, [2] ovf_ie, [1:0] clk_sel (00 div2, 01 div4, 10 div8, 11 div16).
REQ-013 Write takes effect on the cycle psel&penable&pwrite is high; prdata valid in the same access cycle (combinational from registers).
REQ-014 pslverr=1 in the access phase when the channel index >= NUM_CH; such writes are ignored and reads return 0.
REQ-015 While load=1: TCNT<=TDR every cycle, prescaler held at 0, no ticks, no flags.
REQ-016 Prescaler: free-running divider, cleared while en=0 or load=1; one tick when it reaches N-1 (N per clk_sel); first tick N cycles after en rises.
REQ-017 Up count (dw=0), tick: TCNT==max -> ovf set, TCNT <= (auto-reload ? TDR : 0); else TCNT+1.
REQ-018 Down count (dw=1), tick: TCNT==0 -> udf set, TCNT <= (auto-reload ? TDR : max); else TCNT-1.
REQ-019 TSR: bit1 udf, bit0 ovf; writing 0 to a bit clears it, writing 1 has no effect; a set event in the same cycle as a clear wins.
REQ-020 irq[i] = (udf & udf_ie) | (ovf & ovf_ie), registered-flag based, no extra latency beyond the flag.
REQ-021 A clk_sel change mid-count takes effect on the next prescaler wrap; TCNT is not disturbed.
REQ-022 A TDR write does not change TCNT unless load=1 or an auto-reload wrap occurs.
REQ-023 Channels are fully independent; simultaneous events in different channels are all captured.

Reset
REQ-024 On preset=1: TDR=0, TCR=0, TSR=0, TCNT=0, prescaler=0, irq=0, prdata=0, pslverr=0 for all channels.
REQ-025 Reset asserted mid-count aborts counting; first tick after release requires en to be written again.

Structure
REQ-026 Package timer_pkg SHALL hold register offsets, TCR/TSR bit positions, clk_sel encodings and divider values.
REQ-027 Sub-module timer_ch SHALL implement one channel (prescaler, counter, TDR/TCR/TSR); top instantiates NUM_CH copies plus APB decode/readback mux.

Verification
REQ-028 CNT_W=8: TDR=0xFF, TCR=0x80, then TCR=0x32 -> TSR=0x00 after 220*8 pclk, TSR=0x02 after 256*8 pclk; write TSR=0 -> reads 0x00.
REQ-029 CNT_W=16, up, div2, TDR=0xFFF0, load then TCR=0x10 -> TSR=0x01 after 16*2 pclk; TCNT then reads 0x0000.
REQ-030 Auto-reload down, TDR=3, TCR=0x78 (div2, udf_ie) -> irq[0] rises every 4*2 pclk after clear; TCNT reloads 3 on each wrap.
REQ-031 Udf event in the same cycle as TSR write 0 -> TSR bit1 remains 1.
REQ-032 NUM_CH=2, access paddr=0x20 -> pslverr=1, prdata=0, no register changes; ch0 and ch1 with different clk_sel run concurrently and flag at the expected cycles.
REQ-033 preset asserted mid-count -> all registers, irq and TCNT read 0 the cycle after.
